// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter
//   Arbitrates a single-ported program memory between an instruction fetch
//   port and a boot/debug loader port. In BOOT only the loader is served; in
//   RUN the loader has priority but a pending fetch is forced through after
//   STARVE_LIMIT consecutive loader grants. Responses arrive exactly one
//   cycle after acceptance.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   fetch_req_valid/_ready     fetch request handshake, fetch_addr byte address
//   fetch_rsp_valid/_err/_data fetch response (one-cycle strobe)
//   ld_req_valid/_ready        loader request handshake
//   ld_we, ld_addr, ld_wdata   loader write select, byte address, write data
//   ld_rsp_valid/_data         loader response (one-cycle strobe)
//   ld_boot_done               pulse ending the boot phase
//   run_mode                   high in RUN
//   mem_*                      program memory port (combinational read)
module program_memory_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MEM_BYTES    = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req_valid,
  output logic        fetch_req_ready,
  input  logic [31:0] fetch_addr,
  output logic        fetch_rsp_valid,
  output logic        fetch_rsp_err,
  output logic [31:0] fetch_rsp_data,
  input  logic        ld_req_valid,
  input  logic        ld_we,
  output logic        ld_req_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic        ld_rsp_valid,
  output logic [31:0] ld_rsp_data,
  input  logic        ld_boot_done,
  output logic        run_mode,
  output logic [31:0] mem_byte_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int          CW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  logic          fetch_rsp_valid_q, fetch_rsp_valid_d;
  logic          fetch_rsp_err_q, fetch_rsp_err_d;
  logic [31:0]   fetch_rsp_data_q, fetch_rsp_data_d;
  logic          ld_rsp_valid_q, ld_rsp_valid_d;
  logic [31:0]   ld_rsp_data_q, ld_rsp_data_d;

  logic          fetch_grant, ld_grant;
  logic          fetch_err, ld_err;
  logic          at_limit;

  assign fetch_err = (fetch_addr > LAST_WORD) | fetch_addr[0];
  assign ld_err    = (ld_addr > LAST_WORD);
  assign at_limit  = (starve_cnt_q == LIMIT);

  // State transition
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT && ld_boot_done) begin
      state_d = ST_RUN;
    end
  end

  // Grant selection; reset masks both grants so nothing is accepted in a
  // reset cycle even before state_q has settled to BOOT.
  always_comb begin
    fetch_grant = 1'b0;
    ld_grant    = 1'b0;
    if (!reset) begin
      if (state_q == ST_BOOT) begin
        ld_grant = ld_req_valid;
      end else if (fetch_req_valid && (at_limit || !ld_req_valid)) begin
        fetch_grant = 1'b1;
      end else begin
        ld_grant = ld_req_valid;
      end
    end
  end

  // Starvation counter only tracks RUN-phase contention; BOOT keeps it clear
  // so the fairness pattern starts fresh on entering RUN.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q != ST_RUN || !fetch_req_valid || fetch_grant) begin
      starve_cnt_d = '0;
    end else if (ld_grant && !at_limit) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Memory port: erroneous requests are accepted but never touch memory.
  always_comb begin
    mem_byte_address = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    if (fetch_grant && !fetch_err) begin
      mem_byte_address = fetch_addr;
    end else if (ld_grant && !ld_err) begin
      mem_byte_address = ld_addr;
      mem_write_data   = ld_wdata;
      mem_write_enable = ld_we;
    end
  end

  // Response capture at the accept edge; data holds between responses.
  always_comb begin
    fetch_rsp_valid_d = fetch_grant;
    fetch_rsp_err_d   = fetch_grant & fetch_err;
    fetch_rsp_data_d  = fetch_rsp_data_q;
    ld_rsp_valid_d    = ld_grant;
    ld_rsp_data_d     = ld_rsp_data_q;
    if (fetch_grant) begin
      fetch_rsp_data_d = fetch_err ? '0 : mem_read_data;
    end
    if (ld_grant) begin
      ld_rsp_data_d = (ld_err || ld_we) ? '0 : mem_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_BOOT;
      starve_cnt_q      <= '0;
      fetch_rsp_valid_q <= 1'b0;
      fetch_rsp_err_q   <= 1'b0;
      fetch_rsp_data_q  <= '0;
      ld_rsp_valid_q    <= 1'b0;
      ld_rsp_data_q     <= '0;
    end else begin
      state_q           <= state_d;
      starve_cnt_q      <= starve_cnt_d;
      fetch_rsp_valid_q <= fetch_rsp_valid_d;
      fetch_rsp_err_q   <= fetch_rsp_err_d;
      fetch_rsp_data_q  <= fetch_rsp_data_d;
      ld_rsp_valid_q    <= ld_rsp_valid_d;
      ld_rsp_data_q     <= ld_rsp_data_d;
    end
  end

  // Outputs are masked by reset so a response registered just before reset
  // rises is never presented, and RUN is not reported during reset.
  assign fetch_req_ready = fetch_grant;
  assign ld_req_ready    = ld_grant;
  assign run_mode        = (state_q == ST_RUN) && !reset;
  assign fetch_rsp_valid = fetch_rsp_valid_q & ~reset;
  assign fetch_rsp_err   = fetch_rsp_err_q & ~reset;
  assign fetch_rsp_data  = reset ? '0 : fetch_rsp_data_q;
  assign ld_rsp_valid    = ld_rsp_valid_q & ~reset;
  assign ld_rsp_data     = reset ? '0 : ld_rsp_data_q;

endmodule
